// File: rtl/fir_serial_framer.sv
// fir_serial_framer: serial-to-parallel sample deserialiser plus FIFO-buffered result serialiser
// with bit-enable, frame resync, selectable bit order and sticky overrun.
module fir_serial_framer #(
   parameter int IN_W       = 16,
   parameter int OUT_W      = 32,
   parameter int MSB_FIRST  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              serial_in,
   input  logic                              serial_in_en,
   input  logic                              frame_sync,
   output logic [IN_W-1:0]                   sample_data,
   output logic                              sample_valid,
   input  logic [OUT_W-1:0]                  result_data,
   input  logic                              result_valid,
   output logic                              serial_out,
   output logic                              serial_out_valid,
   output logic                              frame_start,
   output logic                              overrun,
   input  logic                              err_clr,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
   localparam int CW = $clog2(IN_W);
   localparam int BW = $clog2(OUT_W);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);

   typedef enum logic {IDLE, SHIFT} state_t;

   logic [CW-1:0]    cnt_q, cnt_d, idx;
   logic [IN_W-1:0]  sh_q, sh_d, sample_data_q, sample_data_d;
   logic             sample_valid_q, sample_valid_d;
   logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
   logic [OUT_W-1:0] head, sr_q, sr_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]    level_q, level_d;
   logic             pop, push, ov_q, ov_d;
   state_t           state_q, state_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic             so_q, so_d, sov_q, sov_d, fs_q, fs_d;

   // frame_sync with an enabled bit makes that bit position 0 of a fresh word
   always_comb begin
      idx            = frame_sync ? '0 : cnt_q;
      sh_d           = sh_q;
      cnt_d          = idx;
      sample_data_d  = sample_data_q;
      sample_valid_d = 1'b0;
      if (serial_in_en) begin
         sh_d  = (MSB_FIRST != 0) ? {sh_q[IN_W-2:0], serial_in} : {serial_in, sh_q[IN_W-1:1]};
         cnt_d = (idx == CW'(IN_W-1)) ? '0 : idx + CW'(1);
         if (idx == CW'(IN_W-1)) begin
            sample_data_d  = sh_d;
            sample_valid_d = 1'b1;
         end
      end
   end

   assign head    = mem_q[rd_q];
   assign pop     = (state_q == IDLE) && (level_q != '0);
   assign push    = result_valid && ((level_q != LW'(FIFO_DEPTH)) || pop);
   assign level_d = level_q + LW'(push) - LW'(pop);
   assign wr_d    = wr_q + PW'(push);
   assign rd_d    = rd_q + PW'(pop);
   assign ov_d    = (result_valid && !push) || (ov_q && !err_clr);

   // Returning to IDLE on the last bit lets IDLE pop the next word on the very next edge
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcnt_d  = bcnt_q;
      so_d    = 1'b0;
      sov_d   = 1'b0;
      fs_d    = 1'b0;
      if (pop) begin
         so_d    = (MSB_FIRST != 0) ? head[OUT_W-1] : head[0];
         sr_d    = (MSB_FIRST != 0) ? head << 1 : head >> 1;
         bcnt_d  = BW'(1);
         sov_d   = 1'b1;
         fs_d    = 1'b1;
         state_d = SHIFT;
      end else if (state_q == SHIFT) begin
         so_d    = (MSB_FIRST != 0) ? sr_q[OUT_W-1] : sr_q[0];
         sr_d    = (MSB_FIRST != 0) ? sr_q << 1 : sr_q >> 1;
         bcnt_d  = bcnt_q + BW'(1);
         sov_d   = 1'b1;
         state_d = (bcnt_q == BW'(OUT_W-1)) ? IDLE : SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q          <= '0;
         sh_q           <= '0;
         sample_data_q  <= '0;
         sample_valid_q <= 1'b0;
         wr_q           <= '0;
         rd_q           <= '0;
         level_q        <= '0;
         ov_q           <= 1'b0;
         state_q        <= IDLE;
         sr_q           <= '0;
         bcnt_q         <= '0;
         so_q           <= 1'b0;
         sov_q          <= 1'b0;
         fs_q           <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         sh_q           <= sh_d;
         sample_data_q  <= sample_data_d;
         sample_valid_q <= sample_valid_d;
         wr_q           <= wr_d;
         rd_q           <= rd_d;
         level_q        <= level_d;
         ov_q           <= ov_d;
         state_q        <= state_d;
         sr_q           <= sr_d;
         bcnt_q         <= bcnt_d;
         so_q           <= so_d;
         sov_q          <= sov_d;
         fs_q           <= fs_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= result_data;
   end

   assign sample_data      = sample_data_q;
   assign sample_valid     = sample_valid_q;
   assign serial_out       = so_q;
   assign serial_out_valid = sov_q;
   assign frame_start      = fs_q;
   assign overrun          = ov_q;
   assign fifo_level       = level_q;
endmodule

// File: tb/tb_fir_serial_framer.sv
// tb_fir_serial_framer: MSB-first and LSB-first instances driven in lockstep and compared every
// cycle against a queue-based reference model, plus directed literal checks.
module tb_fir_serial_framer;
   logic        clk = 1'b0;
   logic        rst_n, serial_in, serial_in_en, frame_sync, result_valid, err_clr;
   logic [31:0] result_data;
   logic [15:0] sd_m, sd_l;
   logic        sv_m, sv_l, so_m, so_l, sov_m, sov_l, fs_m, fs_l, ov_m, ov_l;
   logic [2:0]  lvl_m, lvl_l;

   int tests = 0;
   int failed = 0;

   bit          bits[$];
   logic [15:0] exp_sd_m, exp_sd_l;
   bit          exp_sv, exp_v, exp_fs, exp_ov;
   logic [31:0] q[$];
   logic [31:0] cur;
   int          tx_left, bidx;

   always #5 clk = ~clk;

   fir_serial_framer #(.IN_W(16), .OUT_W(32), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_msb (
      .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .serial_in_en(serial_in_en),
      .frame_sync(frame_sync), .sample_data(sd_m), .sample_valid(sv_m),
      .result_data(result_data), .result_valid(result_valid), .serial_out(so_m),
      .serial_out_valid(sov_m), .frame_start(fs_m), .overrun(ov_m), .err_clr(err_clr),
      .fifo_level(lvl_m));

   fir_serial_framer #(.IN_W(16), .OUT_W(32), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_lsb (
      .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .serial_in_en(serial_in_en),
      .frame_sync(frame_sync), .sample_data(sd_l), .sample_valid(sv_l),
      .result_data(result_data), .result_valid(result_valid), .serial_out(so_l),
      .serial_out_valid(sov_l), .frame_start(fs_l), .overrun(ov_l), .err_clr(err_clr),
      .fifo_level(lvl_l));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      bits.delete();
      q.delete();
      exp_sd_m = '0; exp_sd_l = '0;
      exp_sv = 0; exp_v = 0; exp_fs = 0; exp_ov = 0;
      cur = '0; tx_left = 0; bidx = 0;
   endtask

   task automatic check_all();
      chk("sample_valid_m", sv_m, exp_sv);
      chk("sample_valid_l", sv_l, exp_sv);
      chk("sample_data_m", sd_m, exp_sd_m);
      chk("sample_data_l", sd_l, exp_sd_l);
      chk("out_valid_m", sov_m, exp_v);
      chk("out_valid_l", sov_l, exp_v);
      chk("frame_start_m", fs_m, exp_fs);
      chk("frame_start_l", fs_l, exp_fs);
      chk("serial_out_m", so_m, exp_v ? cur[31-bidx] : 1'b0);
      chk("serial_out_l", so_l, exp_v ? cur[bidx] : 1'b0);
      chk("overrun_m", ov_m, exp_ov);
      chk("overrun_l", ov_l, exp_ov);
      chk("fifo_level_m", lvl_m, q.size());
      chk("fifo_level_l", lvl_l, q.size());
   endtask

   // Advance the model by one edge from the currently driven inputs, then compare after the edge
   task automatic tick();
      int sz;
      bit pop, acc;
      if (!rst_n) mreset();
      else begin
         exp_sv = 0;
         if (serial_in_en) begin
            if (frame_sync) bits.delete();
            bits.push_back(serial_in);
            if (bits.size() == 16) begin
               for (int i = 0; i < 16; i++) begin
                  exp_sd_m[15-i] = bits[i];
                  exp_sd_l[i]    = bits[i];
               end
               exp_sv = 1;
               bits.delete();
            end
         end else if (frame_sync) bits.delete();
         sz  = q.size();
         pop = (sz != 0) && (tx_left == 0);
         acc = result_valid && ((sz < 4) || pop);
         if (pop) begin
            cur = q.pop_front(); bidx = 0; tx_left = 31; exp_v = 1; exp_fs = 1;
         end else if (tx_left > 0) begin
            tx_left--; bidx++; exp_fs = 0;
         end else begin
            exp_v = 0; exp_fs = 0;
         end
         if (acc) q.push_back(result_data);
         exp_ov = (result_valid && !acc) || (exp_ov && !err_clr);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drv(input bit en, input bit sin, input bit fsy, input bit rv,
                      input logic [31:0] rd, input bit ec);
      serial_in_en = en; serial_in = sin; frame_sync = fsy;
      result_valid = rv; result_data = rd; err_clr = ec;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(0, 0, 0, 0, '0, 0);
   endtask

   initial begin
      logic [15:0] w;
      rst_n = 0;
      mreset();
      drv(0, 0, 0, 0, '0, 0);
      drv(0, 0, 0, 0, '0, 0);
      chk("reset_level", lvl_m, 3'd0);
      chk("reset_valid", sov_m, 1'b0);
      rst_n = 1;
      idle(2);

      w = 16'hA5C3;
      for (int i = 15; i >= 0; i--) drv(1, w[i], 0, 0, '0, 0);
      chk("a5c3_valid", sv_m, 1'b1);
      chk("a5c3_data", sd_m, 16'hA5C3);
      idle(1);
      chk("a5c3_pulse_end", sv_m, 1'b0);

      for (int i = 15; i >= 0; i--) begin
         drv(1, w[i], 0, 0, '0, 0);
         if (i == 0) chk("gap_data", sd_m, 16'hA5C3);
         drv(0, 0, 0, 0, '0, 0);
      end
      drv(1, 1, 0, 0, '0, 0);
      drv(1, 1, 0, 0, '0, 0);
      drv(1, 0, 0, 0, '0, 0);
      drv(0, 0, 1, 0, '0, 0);
      w = 16'h1234;
      for (int i = 15; i >= 0; i--) drv(1, w[i], 0, 0, '0, 0);
      chk("resync_data", sd_m, 16'h1234);
      chk("resync_valid", sv_m, 1'b1);

      drv(0, 0, 0, 1, 32'h12345678, 0);
      chk("lat_not_yet", sov_m, 1'b0);
      idle(1);
      chk("lat_valid", sov_m, 1'b1);
      chk("lat_fstart", fs_m, 1'b1);
      idle(40);

      drv(0, 0, 0, 1, 32'hDEADBEEF, 0);
      drv(0, 0, 0, 1, 32'h0000FFFF, 0);
      idle(70);
      chk("b2b_level", lvl_m, 3'd0);

      for (int i = 0; i < 6; i++) drv(0, 0, 0, 1, $urandom, 0);
      chk("ovr_set", ov_m, 1'b1);
      idle(200);
      chk("ovr_sticky", ov_m, 1'b1);
      drv(0, 0, 0, 0, '0, 1);
      chk("ovr_clear", ov_m, 1'b0);

      drv(1, 1, 0, 0, '0, 0);
      for (int i = 0; i < 15; i++) drv(1, 0, 0, 0, '0, 0);
      chk("lsb_data", sd_l, 16'h0001);

      drv(0, 0, 0, 1, 32'hFFFFFFFF, 0);
      idle(10);
      rst_n = 0;
      #1;
      mreset();
      chk("arst_out", so_m, 1'b0);
      chk("arst_valid", sov_m, 1'b0);
      chk("arst_level", lvl_m, 3'd0);
      idle(2);
      rst_n = 1;
      idle(40);

      for (int i = 0; i < 1600; i++)
         drv($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0,
             $urandom_range(0, 99) < ((i % 400) < 100 ? 40 : 2), $urandom,
             $urandom_range(0, 63) == 0);
      idle(200);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
